pic_param_core: RTL and testbench

//  Parametrised synchronous successor of the 8259-style PIC core: N interrupt inputs,
//  IRR/IMR/ISR, rotating priority with fully-nested INT, edge/level trigger, auto-EOI.

---
 rtl/pic_pkg.sv | 34 +++
 rtl/pic_priority_resolver.sv | 27 ++
 rtl/pic_param_core.sv | 198 +++++++++++++++++++
 tb/tb_pic_param_core.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared constants, FSM state type and priority helper for the parametrised PIC core.
package pic_pkg;

  // Register addresses
  localparam logic [1:0] AddrCtrl = 2'd0;
  localparam logic [1:0] AddrImr  = 2'd1;
  localparam logic [1:0] AddrBase = 2'd2;
  localparam logic [1:0] AddrCmd  = 2'd3;

  // Command opcodes, carried in data_in[7:5] of a write to AddrCmd
  localparam logic [2:0] OpEoi        = 3'b001;
  localparam logic [2:0] OpSpecEoi    = 3'b011;
  localparam logic [2:0] OpRotEoi     = 3'b101;
  localparam logic [2:0] OpRotSpecEoi = 3'b111;
  localparam logic [2:0] OpSetPrio    = 3'b110;

  // Bit positions inside the control register
  localparam int unsigned CtrlLtim    = 0;
  localparam int unsigned CtrlAeoi    = 1;
  localparam int unsigned CtrlRotAeoi = 2;

  typedef enum logic [1:0] {
    StIdle,
    StAck1,
    StVec
  } pic_state_e;

  // Rank of a level relative to the lowest-priority pointer; 0 is the highest priority.
  function automatic int unsigned prio_rank(input int unsigned id, input int unsigned ptr,
                                            input int unsigned n);
    return (id + n - ptr - 1) % n;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational rotating priority encoder: first set request scanning from ptr+1 mod N.
module pic_priority_resolver #(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  // Scan from the far end so the nearest set bit after ptr is the last one assigned.
  always_comb begin
    logic [ID_W-1:0] idx;
    valid_o = 1'b0;
    id_o    = '0;
    idx     = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      idx = ID_W'((32'(ptr_i) + i) % NUM_REQ);
      if (req_i[idx]) begin
        valid_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/pic_param_core.sv
// Parametrised 8259-style interrupt controller core: IRR/IMR/ISR, rotating priority,
// edge/level trigger, auto-EOI and a two-pulse INTA handshake delivering the vector.
module pic_param_core
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ  = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned VECTOR_W = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NUM_IRQ-1:0]  irq_i,
  input  logic                wr_en_i,
  input  logic                rd_en_i,
  input  logic [1:0]          addr_i,
  input  logic [DATA_W-1:0]   data_in_i,
  output logic [DATA_W-1:0]   data_out_o,
  input  logic                inta_i,
  output logic                int_out_o,
  output logic [VECTOR_W-1:0] vector_out_o,
  output logic                vector_valid_o
);

  localparam int unsigned ID_W = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0]  irr_q, irr_d, imr_q, imr_d, isr_q, isr_d, irq_prev_q;
  logic [NUM_IRQ-1:0]  isr_set, isr_clr, irr_clr;
  logic [VECTOR_W-1:0] base_q, base_d, vec_q, vec_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [ID_W-1:0]     ptr_q, ptr_d, id_q, id_d;
  logic                spur_q, spur_d, int_q, int_d, vec_valid_q, vec_valid_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  pic_state_e          state_q, state_d;

  logic            pend_valid, isr_valid, int_req;
  logic [ID_W-1:0] pend_id, isr_id, lvl;
  logic [2:0]      op;
  logic            lvl_ok;
  logic            unused_data;

  assign unused_data = ^data_in_i;

  pic_priority_resolver #(.NUM_REQ(NUM_IRQ), .ID_W(ID_W)) u_req_res (
    .req_i   (irr_q & ~imr_q),
    .ptr_i   (ptr_q),
    .valid_o (pend_valid),
    .id_o    (pend_id)
  );

  pic_priority_resolver #(.NUM_REQ(NUM_IRQ), .ID_W(ID_W)) u_isr_res (
    .req_i   (isr_q),
    .ptr_i   (ptr_q),
    .valid_o (isr_valid),
    .id_o    (isr_id)
  );

  assign op     = data_in_i[7:5];
  assign lvl    = data_in_i[ID_W-1:0];
  assign lvl_ok = 32'(lvl) < NUM_IRQ;

  // Fully nested: only a strictly higher-priority request than the in-service level interrupts.
  assign int_req = pend_valid &&
                   (!isr_valid || prio_rank(32'(pend_id), 32'(ptr_q), NUM_IRQ) <
                                  prio_rank(32'(isr_id), 32'(ptr_q), NUM_IRQ));

  // Next-state: register writes, commands, INTA handshake and read mux, all from start-of-cycle state.
  always_comb begin
    state_d     = state_q;
    imr_d       = imr_q;
    base_d      = base_q;
    ctrl_d      = ctrl_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    spur_d      = spur_q;
    vec_d       = vec_q;
    vec_valid_d = 1'b0;
    dout_d      = dout_q;
    isr_set     = '0;
    isr_clr     = '0;
    irr_clr     = '0;

    if (wr_en_i) begin
      unique case (addr_i)
        AddrCtrl: ctrl_d = data_in_i[2:0];
        AddrImr:  imr_d  = data_in_i[NUM_IRQ-1:0];
        AddrBase: base_d = data_in_i[VECTOR_W-1:0];
        AddrCmd: begin
          case (op)
            OpEoi: if (isr_valid) isr_clr[isr_id] = 1'b1;
            OpRotEoi: begin
              if (isr_valid) begin
                isr_clr[isr_id] = 1'b1;
                ptr_d           = isr_id;
              end
            end
            OpSpecEoi: if (lvl_ok) isr_clr[lvl] = 1'b1;
            OpRotSpecEoi: begin
              if (lvl_ok) begin
                isr_clr[lvl] = 1'b1;
                ptr_d        = lvl;
              end
            end
            OpSetPrio: if (lvl_ok) ptr_d = lvl;
            default: ;
          endcase
        end
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (inta_i) begin
          state_d = StAck1;
          spur_d  = !pend_valid;
          id_d    = pend_valid ? pend_id : ID_W'(NUM_IRQ - 1);
          if (pend_valid) begin
            isr_set[pend_id] = 1'b1;
            irr_clr[pend_id] = 1'b1;
          end
        end
      end
      StAck1: begin
        if (inta_i) begin
          state_d     = StVec;
          vec_d       = {base_q[VECTOR_W-1:ID_W], id_q};
          vec_valid_d = 1'b1;
          if (ctrl_q[CtrlAeoi] && !spur_q) begin
            isr_clr[id_q] = 1'b1;
            if (ctrl_q[CtrlRotAeoi]) ptr_d = id_q;
          end
        end
      end
      StVec:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A fresh edge beats the acknowledge clear; inta set beats a same-cycle EOI.
    if (ctrl_q[CtrlLtim]) begin
      irr_d = irq_i;
    end else begin
      irr_d = (irr_q & ~irr_clr) | (irq_i & ~irq_prev_q);
    end
    isr_d = (isr_q & ~isr_clr) | isr_set;
    int_d = (state_d == StIdle) && int_req;

    if (rd_en_i) begin
      unique case (addr_i)
        AddrCtrl: dout_d = DATA_W'(irr_q);
        AddrImr:  dout_d = DATA_W'(imr_q);
        AddrBase: dout_d = DATA_W'(isr_q);
        AddrCmd:  dout_d = DATA_W'({ctrl_q, base_q});
        default:  dout_d = '0;
      endcase
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      irr_q       <= '0;
      imr_q       <= '1;
      isr_q       <= '0;
      irq_prev_q  <= '0;
      base_q      <= '0;
      ctrl_q      <= '0;
      ptr_q       <= ID_W'(NUM_IRQ - 1);
      id_q        <= '0;
      spur_q      <= 1'b0;
      int_q       <= 1'b0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      irr_q       <= irr_d;
      imr_q       <= imr_d;
      isr_q       <= isr_d;
      irq_prev_q  <= irq_i;
      base_q      <= base_d;
      ctrl_q      <= ctrl_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      spur_q      <= spur_d;
      int_q       <= int_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      dout_q      <= dout_d;
    end
  end

  assign data_out_o     = dout_q;
  assign int_out_o      = int_q;
  assign vector_out_o   = vec_q;
  assign vector_valid_o = vec_valid_q;

endmodule

// File: tb/tb_pic_param_core.sv
// Directed self-checking bench for pic_param_core (NUM_IRQ=8, DATA_W=16, VECTOR_W=8).
module tb_pic_param_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq;
  logic        wr_en, rd_en, inta;
  logic [1:0]  addr;
  logic [15:0] data_in, data_out;
  logic        int_out, vector_valid;
  logic [7:0]  vector_out;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] rdata;
  logic        vv;
  logic [7:0]  vec;

  always #5 clk = ~clk;

  pic_param_core #(.NUM_IRQ(8), .DATA_W(16), .VECTOR_W(8)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .irq_i          (irq),
    .wr_en_i        (wr_en),
    .rd_en_i        (rd_en),
    .addr_i         (addr),
    .data_in_i      (data_in),
    .data_out_o     (data_out),
    .inta_i         (inta),
    .int_out_o      (int_out),
    .vector_out_o   (vector_out),
    .vector_valid_o (vector_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    irq     = '0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    inta    = 1'b0;
    addr    = '0;
    data_in = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    addr    = a;
    data_in = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    rd_en = 1'b1;
    addr  = a;
    tick();
    rd_en = 1'b0;
    d     = data_out;
  endtask

  task automatic inta_pulse(output logic v, output logic [7:0] vo);
    inta = 1'b1;
    tick();
    inta = 1'b0;
    v    = vector_valid;
    vo   = vector_out;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values, basic edge request, vector, non-specific EOI
    do_reset();
    check_eq("rst_int", int_out, 0);
    check_eq("rst_vv", vector_valid, 0);
    check_eq("rst_vec", vector_out, 0);
    check_eq("rst_dout", data_out, 0);
    rd(2'd1, rdata); check_eq("rst_imr", rdata, 16'h00FF);
    rd(2'd0, rdata); check_eq("rst_irr", rdata, 16'h0000);
    rd(2'd3, rdata); check_eq("rst_ctrl_base", rdata, 16'h0000);
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h0008);
    irq = 8'h01;
    tick(); check_eq("t1_lat1", int_out, 0);
    tick(); check_eq("t1_lat2", int_out, 1);
    inta_pulse(vv, vec);
    check_eq("t1_ack1_vv", vv, 0);
    check_eq("t1_ack1_int", int_out, 0);
    inta_pulse(vv, vec);
    check_eq("t1_vv", vv, 1);
    check_eq("t1_vec", vec, 8'h08);
    tick(); check_eq("t1_vv_pulse", vector_valid, 0);
    rd(2'd2, rdata); check_eq("t1_isr", rdata, 16'h0001);
    wr(2'd3, 16'h0020);
    rd(2'd2, rdata); check_eq("t1_isr_eoi", rdata, 16'h0000);
    irq = 8'h00;

    // 2: two simultaneous requests, nesting blocks the lower one until EOI
    do_reset();
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h0008);
    irq = 8'h28;
    tick(); tick();
    check_eq("t2_int", int_out, 1);
    inta_pulse(vv, vec);
    inta_pulse(vv, vec);
    check_eq("t2_vec3", vec, 8'h0B);
    tick(); tick();
    check_eq("t2_int_blocked", int_out, 0);
    rd(2'd0, rdata); check_eq("t2_irr", rdata, 16'h0020);
    rd(2'd2, rdata); check_eq("t2_isr", rdata, 16'h0008);
    wr(2'd3, 16'h0020);
    check_eq("t2_int_eoi_cycle", int_out, 0);
    tick(); check_eq("t2_int_after_eoi", int_out, 1);
    inta_pulse(vv, vec);
    inta_pulse(vv, vec);
    check_eq("t2_vec5", vec, 8'h0D);
    wr(2'd3, 16'h0065);
    rd(2'd2, rdata); check_eq("t2_isr_spec_eoi", rdata, 16'h0000);
    irq = 8'h00;

    // 3: masked request latches in IRR but raises no interrupt until unmasked
    do_reset();
    wr(2'd1, 16'h0004);
    wr(2'd2, 16'h0008);
    irq = 8'h04;
    tick(); tick(); tick();
    check_eq("t3_int_masked", int_out, 0);
    rd(2'd0, rdata); check_eq("t3_irr", rdata, 16'h0004);
    wr(2'd1, 16'h0000);
    check_eq("t3_int_wr_cycle", int_out, 0);
    tick(); check_eq("t3_int_unmasked", int_out, 1);
    irq = 8'h00;

    // 4: auto-EOI with rotation makes IR1 lowest, so IR2 beats IR0
    do_reset();
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h0008);
    wr(2'd0, 16'h0006);
    irq = 8'h02;
    tick(); tick();
    check_eq("t4_int", int_out, 1);
    inta_pulse(vv, vec);
    inta_pulse(vv, vec);
    check_eq("t4_vec1", vec, 8'h09);
    tick();
    rd(2'd2, rdata); check_eq("t4_isr_aeoi", rdata, 16'h0000);
    irq = 8'h00;
    tick();
    irq = 8'h05;
    tick(); tick();
    check_eq("t4_int2", int_out, 1);
    inta_pulse(vv, vec);
    inta_pulse(vv, vec);
    check_eq("t4_vv2", vv, 1);
    check_eq("t4_vec2", vec, 8'h0A);
    rd(2'd3, rdata); check_eq("t4_ctrl_base", rdata, 16'h0608);
    irq = 8'h00;

    // 5: level mode, request withdrawn before acknowledge gives a spurious vector
    do_reset();
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h0008);
    wr(2'd0, 16'h0001);
    irq = 8'h10;
    tick(); tick();
    check_eq("t5_int", int_out, 1);
    rd(2'd0, rdata); check_eq("t5_irr_level", rdata, 16'h0010);
    irq = 8'h00;
    tick();
    inta_pulse(vv, vec);
    inta_pulse(vv, vec);
    check_eq("t5_vv", vv, 1);
    check_eq("t5_vec_spur", vec, 8'h0F);
    rd(2'd2, rdata); check_eq("t5_isr", rdata, 16'h0000);
    rd(2'd0, rdata); check_eq("t5_irr_drop", rdata, 16'h0000);

    // 6: reset in the middle of the handshake
    do_reset();
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h0008);
    irq = 8'h40;
    tick(); tick();
    check_eq("t6_int", int_out, 1);
    inta_pulse(vv, vec);
    check_eq("t6_ack1_int", int_out, 0);
    reset = 1'b1;
    tick();
    check_eq("t6_rst_vv", vector_valid, 0);
    check_eq("t6_rst_int", int_out, 0);
    reset = 1'b0;
    inta_pulse(vv, vec);
    check_eq("t6_after_vv", vv, 0);
    check_eq("t6_after_int", int_out, 0);
    rd(2'd1, rdata); check_eq("t6_imr", rdata, 16'h00FF);
    rd(2'd2, rdata); check_eq("t6_isr", rdata, 16'h0000);
    irq = 8'h00;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
